crc_check: RTL and testbench
============================

Name: crc_check

Overview:
- Receive-side CRC checker for the wide-flit datapath.
- Consumes flits plus the CRC field received with each frame's last flit, recomputes the CRC and compares it.
- Emits one pass/fail verdict per frame, with frame-length checking and error counters.
- Sits after the RX deframer and feeds the drop/accept logic in front of the user FIFO.

Parameters:
- DWIDTH, 512, flit width in bits; must be a multiple of 8 (elaboration fatal otherwise).
- CRC_WIDTH, 16, CRC width.
- PIPE_LVL, 0, pipeline depth of the internal CRC computation; verdict latency is PIPE_LVL+2.
- CRC_POLY, 16'hda5f, generator polynomial.
- INIT, 16'h0, CRC seed.
- XOR_OUT, 16'h0, final xor.
- REFIN, 1'b0, byte-wise bit-reflect the input.
- REFOUT, 1'b0, bit-reflect the result.
- MAX_FLITS, 64, maximum legal frame length in flits (1..65535).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- din  in  DWIDTH  flit data
- flitEn  in  1  flit valid
- dlast  in  1  last flit of frame; qualified by flitEn
- crc_in  in  CRC_WIDTH  received CRC; sampled only when flitEn&dlast
- chk_vld  out  1  one-cycle verdict strobe
- crc_ok  out  1  CRC matched; valid when chk_vld
- len_err  out  1  frame exceeded MAX_FLITS; valid when chk_vld
- crc_calc  out  CRC_WIDTH  recomputed CRC, after REFOUT and XOR_OUT; valid when chk_vld
- in_frame  out  1  high between a frame's first and last flit

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: chk_vld=0, crc_ok=0, len_err=0, crc_calc=0, in_frame=0, all counters 0, CRC accumulator=INIT, alignment pipeline empty.
- CRC engine: per-flit parallel CRC using the same algorithm and parameters as the TX generator.
  - The accumulator reseeds to INIT after each last flit.
  - Cycles without flitEn leave all state unchanged.
- Latency: a last flit at cycle T gives chk_vld=1 at T+PIPE_LVL+2.
  - PIPE_LVL+1 cycles are spent in the computation; one registered compare cycle follows.
- Alignment delay line, depth PIPE_LVL+1:
  - Carries crc_in, valid and len_err alongside the computation.
  - Single-flit frames on consecutive cycles must each get their own verdict, in order; no back-pressure exists.
- crc_ok = (crc_calc == delayed crc_in). len_err is independent of crc_ok.
- FSM:
  - IDLE: flitEn&~dlast → BODY with flit_cnt=1. flitEn&dlast → single-flit frame, stay IDLE.
  - BODY: flitEn&~dlast → flit_cnt+1, stay. flitEn&dlast → IDLE.
  - in_frame = (state==BODY).
- Length: the frame length counts the last flit.
  - len_err = length > MAX_FLITS.
  - flit_cnt saturates at MAX_FLITS+1; no wrap.
- Reset mid-frame: the partial frame is discarded, no verdict is emitted for it, and in-flight verdicts in the delay line are flushed.
- Inputs are ignored while rst=1.

Optional Feature:
- Macro: CRC_CHECK_STATS_EN.
- With the macro defined, three extra output ports exist: frame_cnt[31:0], crc_err_cnt[31:0], len_err_cnt[31:0].
  - Each increments on chk_vld (all frames, ~crc_ok, len_err respectively) and saturates at 32'hFFFFFFFF.
  - All three are cleared by rst.
- Without the macro, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- All-zero frames: PIPE_LVL=0, INIT=0, XOR_OUT=0, 3-flit frame of all-zero data with crc_in=16'h0000 → chk_vld exactly 2 cycles after the last flit, crc_ok=1, crc_calc=16'h0000, len_err=0.
- Corrupted CRC: same frame with crc_in=16'h0001 → crc_ok=0, crc_calc=16'h0000; crc_err_cnt=1 with CRC_CHECK_STATS_EN.
- Random data vs software model: PIPE_LVL=2, random data, crc_in from the software CRC model → crc_ok=1 at T+4. Flip one din bit → crc_ok=0.
- Back-to-back single-flit frames with PIPE_LVL=2: 4 consecutive single-flit frames with alternating good/bad CRC → 4 consecutive chk_vld pulses, crc_ok=1,0,1,0.
- Length check with MAX_FLITS=4: 4-flit frame → len_err=0. 5-flit frame with correct CRC → crc_ok=1, len_err=1. 70000-flit frame → flit_cnt holds at 5, len_err=1.
- Reset mid-frame and idle gaps:
  - rst asserted after flit 2 of a 5-flit frame → no chk_vld for it, in_frame=0. The next good 2-flit frame gives crc_ok=1, showing the accumulator was reseeded.
  - flitEn gaps inserted mid-frame → verdict unchanged.

Source files
------------

// File: rtl/crc_check.sv
// Receive-side CRC checker: recomputes each frame's CRC over wide flits, compares it with the received field
// and checks frame length. Optional counters: define CRC_CHECK_STATS_EN to add frame_cnt/crc_err_cnt/len_err_cnt.
module crc_check #(
    parameter int                   DWIDTH    = 512,
    parameter int                   CRC_WIDTH = 16,
    parameter int                   PIPE_LVL  = 0,
    parameter logic [CRC_WIDTH-1:0] CRC_POLY  = 16'hda5f,
    parameter logic [CRC_WIDTH-1:0] INIT      = 16'h0,
    parameter logic [CRC_WIDTH-1:0] XOR_OUT   = 16'h0,
    parameter logic                 REFIN     = 1'b0,
    parameter logic                 REFOUT    = 1'b0,
    parameter int                   MAX_FLITS = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DWIDTH-1:0]    din,
    input  logic                 flitEn,
    input  logic                 dlast,
    input  logic [CRC_WIDTH-1:0] crc_in,
    output logic                 chk_vld,
    output logic                 crc_ok,
    output logic                 len_err,
    output logic [CRC_WIDTH-1:0] crc_calc,
    output logic                 in_frame
`ifdef CRC_CHECK_STATS_EN
    ,
    output logic [31:0]          frame_cnt,
    output logic [31:0]          crc_err_cnt,
    output logic [31:0]          len_err_cnt
`endif
);

    generate
        if (DWIDTH % 8 != 0) begin : g_bad_dwidth
            $fatal(1, "crc_check: DWIDTH must be a multiple of 8");
        end
        if (MAX_FLITS < 1 || MAX_FLITS > 65535) begin : g_bad_max_flits
            $fatal(1, "crc_check: MAX_FLITS must be in 1..65535");
        end
        if (PIPE_LVL < 0) begin : g_bad_pipe_lvl
            $fatal(1, "crc_check: PIPE_LVL must not be negative");
        end
    endgenerate

    localparam int CNT_W = $clog2(MAX_FLITS + 2);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_FLITS);
    localparam logic [CNT_W-1:0] SAT_CNT = CNT_W'(MAX_FLITS + 1);
    localparam int PD = (PIPE_LVL > 0) ? PIPE_LVL : 1;
    localparam int PL = (PIPE_LVL > 0) ? PIPE_LVL - 1 : 0;

    typedef enum logic {
        IDLE,
        BODY
    } state_t;

    typedef struct packed {
        logic                 vld;
        logic                 last;
        logic                 len_err;
        logic [CRC_WIDTH-1:0] dterm;
        logic [CRC_WIDTH-1:0] crc_rx;
    } stage_t;

    // MSB-first bit-serial CRC over one flit; unrolls into an XOR network.
    function automatic logic [CRC_WIDTH-1:0] crc_shift(input logic [CRC_WIDTH-1:0] crc,
                                                       input logic [DWIDTH-1:0]    d);
        logic [CRC_WIDTH-1:0] c;
        logic                 fb;
        c = crc;
        for (int i = DWIDTH - 1; i >= 0; i--) begin
            fb = c[CRC_WIDTH-1] ^ d[i];
            c  = {c[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
        return c;
    endfunction

    function automatic logic [DWIDTH-1:0] reflect_bytes(input logic [DWIDTH-1:0] d);
        logic [DWIDTH-1:0] r;
        r = '0;
        for (int b = 0; b < DWIDTH / 8; b++) begin
            for (int i = 0; i < 8; i++) begin
                r[b*8+i] = d[b*8+7-i];
            end
        end
        return r;
    endfunction

    function automatic logic [CRC_WIDTH-1:0] reflect_crc(input logic [CRC_WIDTH-1:0] c);
        logic [CRC_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < CRC_WIDTH; i++) begin
            r[i] = c[CRC_WIDTH-1-i];
        end
        return r;
    endfunction

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     flit_cnt_q, flit_cnt_d;
    logic                 frame_len_err;

    stage_t               in_stg;
    stage_t               acc_in;
    stage_t [PD-1:0]      pipe_q, pipe_d;
    logic [DWIDTH-1:0]    din_ref;

    logic [CRC_WIDTH-1:0] acc_q, acc_d;
    logic [CRC_WIDTH-1:0] acc_next;
    logic                 res_vld_q, res_vld_d;
    logic [CRC_WIDTH-1:0] res_crc_q, res_crc_d;
    logic [CRC_WIDTH-1:0] res_rx_q, res_rx_d;
    logic                 res_len_q, res_len_d;

    logic [CRC_WIDTH-1:0] crc_final;
    logic                 chk_vld_q, chk_vld_d;
    logic                 crc_ok_q, crc_ok_d;
    logic                 len_err_q, len_err_d;
    logic [CRC_WIDTH-1:0] crc_calc_q, crc_calc_d;

    // Frame tracking: flit_cnt holds the flits seen before the current one, so length > MAX iff cnt >= MAX at dlast.
    always_comb begin
        state_d       = state_q;
        flit_cnt_d    = flit_cnt_q;
        frame_len_err = 1'b0;
        if (flitEn) begin
            case (state_q)
                IDLE: begin
                    if (!dlast) begin
                        state_d    = BODY;
                        flit_cnt_d = CNT_W'(1);
                    end
                end
                BODY: begin
                    if (dlast) begin
                        state_d       = IDLE;
                        flit_cnt_d    = '0;
                        frame_len_err = (flit_cnt_q >= MAX_CNT);
                    end else if (flit_cnt_q < SAT_CNT) begin
                        flit_cnt_d = flit_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    flit_cnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        din_ref        = REFIN ? reflect_bytes(din) : din;
        in_stg         = '0;
        in_stg.vld     = flitEn;
        in_stg.last    = flitEn & dlast;
        in_stg.len_err = frame_len_err;
        in_stg.dterm   = crc_shift('0, din_ref);
        in_stg.crc_rx  = (flitEn & dlast) ? crc_in : '0;
    end

    // The data-only term has no feedback, so it can be pipelined ahead of the accumulator loop.
    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = in_stg;
        for (int i = 1; i < PD; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        acc_in = (PIPE_LVL == 0) ? in_stg : pipe_q[PL];
    end

    // CRC is linear: crc(acc, d) = crc(acc, 0) ^ crc(0, d), so only the shift of acc stays in the loop.
    always_comb begin
        acc_next  = crc_shift(acc_q, '0) ^ acc_in.dterm;
        acc_d     = acc_q;
        res_vld_d = 1'b0;
        res_crc_d = res_crc_q;
        res_rx_d  = res_rx_q;
        res_len_d = res_len_q;
        if (acc_in.vld) begin
            acc_d = acc_in.last ? INIT : acc_next;
            if (acc_in.last) begin
                res_vld_d = 1'b1;
                res_crc_d = acc_next;
                res_rx_d  = acc_in.crc_rx;
                res_len_d = acc_in.len_err;
            end
        end
    end

    always_comb begin
        crc_final  = (REFOUT ? reflect_crc(res_crc_q) : res_crc_q) ^ XOR_OUT;
        chk_vld_d  = res_vld_q;
        crc_ok_d   = crc_ok_q;
        len_err_d  = len_err_q;
        crc_calc_d = crc_calc_q;
        if (res_vld_q) begin
            crc_ok_d   = (crc_final == res_rx_q);
            len_err_d  = res_len_q;
            crc_calc_d = crc_final;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            flit_cnt_q <= '0;
            pipe_q     <= '0;
            acc_q      <= INIT;
            res_vld_q  <= 1'b0;
            res_crc_q  <= '0;
            res_rx_q   <= '0;
            res_len_q  <= 1'b0;
            chk_vld_q  <= 1'b0;
            crc_ok_q   <= 1'b0;
            len_err_q  <= 1'b0;
            crc_calc_q <= '0;
        end else begin
            state_q    <= state_d;
            flit_cnt_q <= flit_cnt_d;
            pipe_q     <= pipe_d;
            acc_q      <= acc_d;
            res_vld_q  <= res_vld_d;
            res_crc_q  <= res_crc_d;
            res_rx_q   <= res_rx_d;
            res_len_q  <= res_len_d;
            chk_vld_q  <= chk_vld_d;
            crc_ok_q   <= crc_ok_d;
            len_err_q  <= len_err_d;
            crc_calc_q <= crc_calc_d;
        end
    end

    assign chk_vld  = chk_vld_q;
    assign crc_ok   = crc_ok_q;
    assign len_err  = len_err_q;
    assign crc_calc = crc_calc_q;
    assign in_frame = (state_q == BODY);

`ifdef CRC_CHECK_STATS_EN
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [31:0] crc_err_cnt_q, crc_err_cnt_d;
    logic [31:0] len_err_cnt_q, len_err_cnt_d;

    // Counters advance together with the verdict registers so they are current while chk_vld is high.
    always_comb begin
        frame_cnt_d   = frame_cnt_q;
        crc_err_cnt_d = crc_err_cnt_q;
        len_err_cnt_d = len_err_cnt_q;
        if (res_vld_q) begin
            if (frame_cnt_q != 32'hFFFF_FFFF) begin
                frame_cnt_d = frame_cnt_q + 32'd1;
            end
            if ((crc_final != res_rx_q) && (crc_err_cnt_q != 32'hFFFF_FFFF)) begin
                crc_err_cnt_d = crc_err_cnt_q + 32'd1;
            end
            if (res_len_q && (len_err_cnt_q != 32'hFFFF_FFFF)) begin
                len_err_cnt_d = len_err_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q   <= '0;
            crc_err_cnt_q <= '0;
            len_err_cnt_q <= '0;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            crc_err_cnt_q <= crc_err_cnt_d;
            len_err_cnt_q <= len_err_cnt_d;
        end
    end

    assign frame_cnt   = frame_cnt_q;
    assign crc_err_cnt = crc_err_cnt_q;
    assign len_err_cnt = len_err_cnt_q;
`endif

endmodule

// File: tb/tb_crc_check.sv
// Directed bench for crc_check: PIPE_LVL=0 and PIPE_LVL=2 instances share one stimulus stream and their
// verdicts are compared against a bit-serial CRC model and hand-derived expectations.
`timescale 1ns/1ps
module tb_crc_check;

    localparam int            DW   = 64;
    localparam int            CW   = 16;
    localparam int            MAXF = 4;
    localparam logic [CW-1:0] POLY = 16'hda5f;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din;
    logic          flit_en;
    logic          dlast;
    logic [CW-1:0] crc_in;

    logic          chk_vld0, crc_ok0, len_err0, in_frame0;
    logic [CW-1:0] crc_calc0;
    logic          chk_vld2, crc_ok2, len_err2, in_frame2;
    logic [CW-1:0] crc_calc2;
`ifdef CRC_CHECK_STATS_EN
    logic [31:0]   frame_cnt0, crc_err_cnt0, len_err_cnt0;
    logic [31:0]   frame_cnt2, crc_err_cnt2, len_err_cnt2;
`endif

    always #5 clk = ~clk;

    crc_check #(.DWIDTH(DW), .PIPE_LVL(0), .MAX_FLITS(MAXF)) u_dut0 (
        .clk(clk), .rst(rst), .din(din), .flitEn(flit_en), .dlast(dlast), .crc_in(crc_in),
        .chk_vld(chk_vld0), .crc_ok(crc_ok0), .len_err(len_err0), .crc_calc(crc_calc0),
        .in_frame(in_frame0)
`ifdef CRC_CHECK_STATS_EN
        , .frame_cnt(frame_cnt0), .crc_err_cnt(crc_err_cnt0), .len_err_cnt(len_err_cnt0)
`endif
    );

    crc_check #(.DWIDTH(DW), .PIPE_LVL(2), .MAX_FLITS(MAXF)) u_dut2 (
        .clk(clk), .rst(rst), .din(din), .flitEn(flit_en), .dlast(dlast), .crc_in(crc_in),
        .chk_vld(chk_vld2), .crc_ok(crc_ok2), .len_err(len_err2), .crc_calc(crc_calc2),
        .in_frame(in_frame2)
`ifdef CRC_CHECK_STATS_EN
        , .frame_cnt(frame_cnt2), .crc_err_cnt(crc_err_cnt2), .len_err_cnt(len_err_cnt2)
`endif
    );

    typedef struct {
        int            cyc;
        logic          ok;
        logic          len;
        logic [CW-1:0] calc;
    } verdict_t;

    typedef struct {
        int nflits;
        bit zero;
        bit bad;
        int flip;
        bit gaps;
        bit exp_ok;
        bit exp_len;
    } vec_t;

    int            cyc = 0;
    int            last_cyc = 0;
    int            tests = 0;
    int            fails = 0;
    int            exp_frames = 0;
    int            exp_crc_errs = 0;
    int            exp_len_errs = 0;
    logic [CW-1:0] exp_calc;
    logic [DW-1:0] frame_buf [8];
    verdict_t      vq0 [$];
    verdict_t      vq2 [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Log every verdict strobe with the cycle it was seen in.
    always @(negedge clk) begin
        verdict_t v;
        if (chk_vld0) begin
            v.cyc = cyc; v.ok = crc_ok0; v.len = len_err0; v.calc = crc_calc0;
            vq0.push_back(v);
        end
    end

    always @(negedge clk) begin
        verdict_t v;
        if (chk_vld2) begin
            v.cyc = cyc; v.ok = crc_ok2; v.len = len_err2; v.calc = crc_calc2;
            vq2.push_back(v);
        end
    end

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference CRC: INIT=0, XOR_OUT=0, no reflection, flit MSB first.
    function automatic logic [CW-1:0] model_crc(input int n);
        logic [CW-1:0] c;
        logic          fb;
        c = '0;
        for (int f = 0; f < n; f++) begin
            for (int i = DW - 1; i >= 0; i--) begin
                fb = c[CW-1] ^ frame_buf[f][i];
                c  = {c[CW-2:0], 1'b0} ^ (fb ? POLY : 16'h0000);
            end
        end
        return c;
    endfunction

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic put_flit(input logic [DW-1:0] d, input logic last, input logic [CW-1:0] c);
        @(negedge clk);
        din     = d;
        flit_en = 1'b1;
        dlast   = last;
        crc_in  = c;
        if (last) last_cyc = cyc;
    endtask

    task automatic put_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            flit_en = 1'b0;
            dlast   = 1'b0;
            din     = '0;
            crc_in  = '0;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [CW-1:0] good;
        logic [CW-1:0] rx;
        logic [DW-1:0] tmp;
        for (int f = 0; f < v.nflits; f++) begin
            frame_buf[f] = v.zero ? '0 : {$urandom(), $urandom()};
        end
        good = model_crc(v.nflits);
        if (v.flip >= 0) begin
            tmp = frame_buf[v.nflits/2];
            tmp[v.flip] = ~tmp[v.flip];
            frame_buf[v.nflits/2] = tmp;
        end
        exp_calc = model_crc(v.nflits);
        rx = v.bad ? (good ^ 16'h0001) : good;
        for (int f = 0; f < v.nflits; f++) begin
            put_flit(frame_buf[f], (f == v.nflits - 1), (f == v.nflits - 1) ? rx : 16'h0000);
            if (v.gaps && (f != v.nflits - 1)) put_idle(2);
        end
        put_idle(8);
    endtask

    task automatic check_verdict(input string name, input verdict_t v, input int lat,
                                 input logic exp_ok, input logic exp_len, input logic [CW-1:0] calc);
        check_val({name, " latency"}, v.cyc - last_cyc, lat);
        check_val({name, " crc_ok"}, v.ok, exp_ok);
        check_val({name, " len_err"}, v.len, exp_len);
        check_val({name, " crc_calc"}, v.calc, calc);
    endtask

    task automatic checkOutput(input string name, input logic exp_ok, input logic exp_len,
                               input logic [CW-1:0] calc);
        #1;
        check_val({name, " p0 verdicts"}, vq0.size(), 1);
        if (vq0.size() > 0) check_verdict({name, " p0"}, vq0.pop_front(), 2, exp_ok, exp_len, calc);
        check_val({name, " p2 verdicts"}, vq2.size(), 1);
        if (vq2.size() > 0) check_verdict({name, " p2"}, vq2.pop_front(), 4, exp_ok, exp_len, calc);
        vq0.delete();
        vq2.delete();
        exp_frames++;
        if (!exp_ok) exp_crc_errs++;
        if (exp_len) exp_len_errs++;
    endtask

    task automatic check_stats(input string name);
`ifdef CRC_CHECK_STATS_EN
        check_val({name, " p0 frame_cnt"}, frame_cnt0, exp_frames);
        check_val({name, " p0 crc_err_cnt"}, crc_err_cnt0, exp_crc_errs);
        check_val({name, " p0 len_err_cnt"}, len_err_cnt0, exp_len_errs);
        check_val({name, " p2 frame_cnt"}, frame_cnt2, exp_frames);
        check_val({name, " p2 crc_err_cnt"}, crc_err_cnt2, exp_crc_errs);
        check_val({name, " p2 len_err_cnt"}, len_err_cnt2, exp_len_errs);
`else
        check_val({name, " p0 in_frame idle"}, in_frame0, 0);
`endif
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        flit_en = 1'b0;
        dlast   = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_frames   = 0;
        exp_crc_errs = 0;
        exp_len_errs = 0;
    endtask

    initial begin
        vec_t          vecs [9];
        verdict_t      v;
        int            lc [4];
        logic [CW-1:0] good;
        logic [DW-1:0] d;

        vecs[0] = '{3, 1'b1, 1'b0, -1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{3, 1'b1, 1'b1, -1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{3, 1'b0, 1'b0, -1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{3, 1'b0, 1'b0, 17, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{4, 1'b0, 1'b0, -1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{5, 1'b0, 1'b0, -1, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{4, 1'b0, 1'b0, -1, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{1, 1'b0, 1'b0, -1, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{6, 1'b1, 1'b1, -1, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; flit_en = 1'b0; dlast = 1'b0; din = '0; crc_in = '0;
        repeat (3) @(negedge clk);
        check_val("reset p0 chk_vld", chk_vld0, 0);
        check_val("reset p0 crc_ok", crc_ok0, 0);
        check_val("reset p0 len_err", len_err0, 0);
        check_val("reset p0 crc_calc", crc_calc0, 0);
        check_val("reset p0 in_frame", in_frame0, 0);
        check_val("reset p2 chk_vld", chk_vld2, 0);
        check_val("reset p2 crc_calc", crc_calc2, 0);
        check_val("reset p2 in_frame", in_frame2, 0);
        rst = 1'b0;
        check_stats("reset");

        for (int k = 0; k < 9; k++) begin
            applyStimulus(vecs[k]);
            checkOutput($sformatf("vec%0d", k), vecs[k].exp_ok, vecs[k].exp_len, exp_calc);
        end
        check_stats("after vectors");

        // Back-to-back single-flit frames, alternating good and corrupted CRC.
        for (int k = 0; k < 4; k++) begin
            d = {$urandom(), $urandom()};
            frame_buf[0] = d;
            good = model_crc(1);
            put_flit(d, 1'b1, (k % 2 == 0) ? good : ~good);
            lc[k] = last_cyc;
        end
        put_idle(8);
        #1;
        check_val("b2b p0 verdicts", vq0.size(), 4);
        check_val("b2b p2 verdicts", vq2.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (vq0.size() > 0) begin
                v = vq0.pop_front();
                check_val($sformatf("b2b%0d p0 latency", k), v.cyc - lc[k], 2);
                check_val($sformatf("b2b%0d p0 crc_ok", k), v.ok, (k % 2 == 0));
            end
            if (vq2.size() > 0) begin
                v = vq2.pop_front();
                check_val($sformatf("b2b%0d p2 latency", k), v.cyc - lc[k], 4);
                check_val($sformatf("b2b%0d p2 crc_ok", k), v.ok, (k % 2 == 0));
            end
        end
        exp_frames += 4;
        exp_crc_errs += 2;
        check_stats("after b2b");

        // Reset after flit 2 of a 5-flit frame.
        put_flit({$urandom(), $urandom()}, 1'b0, 16'h0000);
        put_flit({$urandom(), $urandom()}, 1'b0, 16'h0000);
        @(negedge clk);
        flit_en = 1'b0;
        check_val("midframe p0 in_frame", in_frame0, 1);
        check_val("midframe p2 in_frame", in_frame2, 1);
        pulse_reset();
        check_val("post-reset p0 in_frame", in_frame0, 0);
        check_val("post-reset p2 in_frame", in_frame2, 0);

        // Reset right behind a last flit flushes its verdict from both pipelines.
        frame_buf[0] = {$urandom(), $urandom()};
        put_flit(frame_buf[0], 1'b1, model_crc(1));
        pulse_reset();
        put_idle(8);
        #1;
        check_val("flush p0 verdicts", vq0.size(), 0);
        check_val("flush p2 verdicts", vq2.size(), 0);
        vq0.delete();
        vq2.delete();

        applyStimulus('{2, 1'b0, 1'b0, -1, 1'b0, 1'b1, 1'b0});
        checkOutput("reseed", 1'b1, 1'b0, exp_calc);

        // Very long frame: the length counter must saturate rather than wrap.
        for (int f = 0; f < 69999; f++) put_flit('0, 1'b0, 16'h0000);
        put_idle(1);
        check_val("long p0 flit_cnt", u_dut0.flit_cnt_q, MAXF + 1);
        check_val("long p2 flit_cnt", u_dut2.flit_cnt_q, MAXF + 1);
        check_val("long p0 in_frame", in_frame0, 1);
        put_flit('0, 1'b1, 16'h0000);
        put_idle(8);
        checkOutput("long", 1'b1, 1'b1, 16'h0000);
        check_stats("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
